ofdm_symbol_sched: RTL and testbench

//  Sequences the FFT demodulator downstream of frame sync.
//  - Consumes the sample stream plus per-symbol timing (symbol_start, CP length, PBCH/SSS markers).
//  - Discards the cyclic prefix and forwards exactly FFT_LEN samples per symbol on an AXI-S master, with tlast on the last beat.
//  - Emits a per-symbol tag (running symbol number, PBCH/SSS flags) so the resource-grid demapper knows what each FFT output is.

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/axis_out_reg.sv | 45 ++++
 rtl/ofdm_symbol_sched.sv | 146 ++++++++++++++
 tb/tb_ofdm_symbol_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared types and default sizes for the OFDM symbol scheduler
package ofdm_pkg;

  localparam int FFT_LEN_DEF    = 256;
  localparam int MAX_CP_LEN_DEF = 20;
  localparam int SYM_CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SKIP_CP,
    PAYLOAD
  } state_t;

  typedef struct packed {
    logic                     pbch;
    logic                     sss;
    logic [SYM_CNT_W_DEF-1:0] num;
  } sym_tag_t;

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry AXI-S output register with sticky overflow flag
module axis_out_reg #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          load_last_i,
  output logic          accept_o,
  output logic [DW-1:0] tdata,
  output logic          tvalid,
  output logic          tlast,
  input  logic          tready,
  output logic          overflow_o
);

  logic stalled;

  // A beat leaving this cycle frees the slot, so a load on the same edge is still taken.
  assign stalled  = tvalid && !tready;
  assign accept_o = load_i && !stalled;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tdata      <= '0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (accept_o) begin
        tdata  <= load_data_i;
        tlast  <= load_last_i;
        tvalid <= 1'b1;
      end else if (tready) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
      if (load_i && stalled) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofdm_symbol_sched.sv
// rtl/ofdm_symbol_sched.sv - drops the cyclic prefix and frames FFT_LEN payload beats per symbol
module ofdm_symbol_sched
  import ofdm_pkg::*;
#(
  parameter int IN_DW      = 32,
  parameter int FFT_LEN    = FFT_LEN_DEF,
  parameter int MAX_CP_LEN = MAX_CP_LEN_DEF,
  parameter int SYM_CNT_W  = SYM_CNT_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [IN_DW-1:0]                s_axis_in_tdata,
  input  logic                            s_axis_in_tvalid,
  input  logic                            symbol_start_i,
  input  logic [$clog2(MAX_CP_LEN+1)-1:0] CP_len_i,
  input  logic                            PBCH_start_i,
  input  logic                            SSS_start_i,
  output logic [IN_DW-1:0]                m_axis_fft_tdata,
  output logic                            m_axis_fft_tvalid,
  output logic                            m_axis_fft_tlast,
  input  logic                            m_axis_fft_tready,
  output logic [SYM_CNT_W+1:0]            sym_tag_o,
  output logic                            sym_tag_valid_o,
  output logic                            abort_o,
  output logic                            overflow_o
);

  localparam int CPW = $clog2(MAX_CP_LEN + 1);
  localparam int PW  = $clog2(FFT_LEN);

  state_t               state;
  logic [CPW-1:0]       cp_cnt;
  logic [CPW-1:0]       cp_len_q;
  logic [PW-1:0]        pay_cnt;
  logic [PW-1:0]        pay_idx;
  logic [SYM_CNT_W-1:0] sym_num;
  logic [SYM_CNT_W-1:0] num_eff;
  logic                 pbch_q;
  logic                 sss_q;
  logic                 pbch_eff;
  logic                 sss_eff;
  logic                 start_now;
  logic                 aborting;
  logic                 load;
  logic                 beat_last;
  logic                 accept;
  logic                 first_beat;

  // A symbol_start with CP length 0 is itself payload beat 0, so the "effective"
  // values merge the incoming start fields with the latched ones.
  always_comb begin
    start_now = s_axis_in_tvalid && symbol_start_i;
    aborting  = start_now && (state != IDLE);
    load      = 1'b0;
    if (start_now) begin
      load = (CP_len_i == '0);
    end else if (s_axis_in_tvalid && (state == PAYLOAD)) begin
      load = 1'b1;
    end
    pay_idx    = start_now ? '0 : pay_cnt;
    beat_last  = (pay_idx == PW'(FFT_LEN - 1));
    num_eff    = sym_num + SYM_CNT_W'(aborting);
    pbch_eff   = start_now ? PBCH_start_i : pbch_q;
    sss_eff    = start_now ? SSS_start_i : sss_q;
    first_beat = accept && (pay_idx == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= IDLE;
      cp_cnt          <= '0;
      cp_len_q        <= '0;
      pay_cnt         <= '0;
      sym_num         <= '0;
      pbch_q          <= 1'b0;
      sss_q           <= 1'b0;
      sym_tag_o       <= '0;
      sym_tag_valid_o <= 1'b0;
      abort_o         <= 1'b0;
    end else begin
      abort_o         <= aborting;
      sym_tag_valid_o <= first_beat;
      if (first_beat) begin
        sym_tag_o <= {pbch_eff, sss_eff, num_eff};
      end
      if (start_now) begin
        cp_len_q <= CP_len_i;
        pbch_q   <= PBCH_start_i;
        sss_q    <= SSS_start_i;
        cp_cnt   <= CPW'(1);
        if (aborting) begin
          sym_num <= sym_num + SYM_CNT_W'(1);
        end
        if (CP_len_i == '0) begin
          state   <= PAYLOAD;
          pay_cnt <= PW'(1);
        end else if (CP_len_i == CPW'(1)) begin
          state   <= PAYLOAD;
          pay_cnt <= '0;
        end else begin
          state   <= SKIP_CP;
          pay_cnt <= '0;
        end
      end else if (s_axis_in_tvalid) begin
        case (state)
          SKIP_CP: begin
            cp_cnt <= cp_cnt + CPW'(1);
            if (cp_cnt == cp_len_q - CPW'(1)) begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            pay_cnt <= pay_cnt + PW'(1);
            if (beat_last) begin
              state   <= IDLE;
              pay_cnt <= '0;
              sym_num <= sym_num + SYM_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Dropped samples still advance pay_cnt above, keeping tlast on the symbol boundary.
  axis_out_reg #(
    .DW(IN_DW)
  ) u_out (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (load),
    .load_data_i (s_axis_in_tdata),
    .load_last_i (beat_last),
    .accept_o    (accept),
    .tdata       (m_axis_fft_tdata),
    .tvalid      (m_axis_fft_tvalid),
    .tlast       (m_axis_fft_tlast),
    .tready      (m_axis_fft_tready),
    .overflow_o  (overflow_o)
  );

  cp_len_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
    (s_axis_in_tvalid && symbol_start_i) |-> (CP_len_i <= CPW'(MAX_CP_LEN)));

endmodule

// File: tb/tb_ofdm_symbol_sched.sv
// tb/tb_ofdm_symbol_sched.sv - randomized self-checking bench for ofdm_symbol_sched
module tb_ofdm_symbol_sched;
  import ofdm_pkg::*;

  localparam int DW    = 32;
  localparam int FFT   = 256;
  localparam int MAXCP = 20;
  localparam int SW    = 16;
  localparam int CPW   = $clog2(MAXCP + 1);

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [DW-1:0]   s_axis_in_tdata;
  logic            s_axis_in_tvalid;
  logic            symbol_start_i;
  logic [CPW-1:0]  CP_len_i;
  logic            PBCH_start_i;
  logic            SSS_start_i;
  logic [DW-1:0]   m_axis_fft_tdata;
  logic            m_axis_fft_tvalid;
  logic            m_axis_fft_tlast;
  logic            m_axis_fft_tready;
  logic [SW+1:0]   sym_tag_o;
  logic            sym_tag_valid_o;
  logic            abort_o;
  logic            overflow_o;

  always #5 clk_i = ~clk_i;

  ofdm_symbol_sched #(
    .IN_DW(DW), .FFT_LEN(FFT), .MAX_CP_LEN(MAXCP), .SYM_CNT_W(SW)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .symbol_start_i    (symbol_start_i),
    .CP_len_i          (CP_len_i),
    .PBCH_start_i      (PBCH_start_i),
    .SSS_start_i       (SSS_start_i),
    .m_axis_fft_tdata  (m_axis_fft_tdata),
    .m_axis_fft_tvalid (m_axis_fft_tvalid),
    .m_axis_fft_tlast  (m_axis_fft_tlast),
    .m_axis_fft_tready (m_axis_fft_tready),
    .sym_tag_o         (sym_tag_o),
    .sym_tag_valid_o   (sym_tag_valid_o),
    .abort_o           (abort_o),
    .overflow_o        (overflow_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-symbol expectations derived from CP length and sample count.
  logic [DW:0] exp_beats[$];
  logic [DW:0] got_beats[$];
  sym_tag_t    exp_tags[$];
  sym_tag_t    got_tags[$];
  int          exp_aborts  = 0;
  int          got_aborts  = 0;
  int          tag_no_beat = 0;
  int          exp_num     = 0;
  bit          in_progress = 0;
  int          cyc         = 0;
  int          p0_cyc      = 0;
  int          tag_cyc     = 0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (m_axis_fft_tvalid && m_axis_fft_tready) got_beats.push_back({m_axis_fft_tlast, m_axis_fft_tdata});
      if (sym_tag_valid_o) begin
        got_tags.push_back(sym_tag_o);
        tag_cyc = cyc;
        if (!m_axis_fft_tvalid) tag_no_beat++;
      end
      if (abort_o) got_aborts++;
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit st, input int cp, input bit pb, input bit ss);
    s_axis_in_tvalid = v;
    s_axis_in_tdata  = d;
    symbol_start_i   = st;
    CP_len_i         = CPW'(cp);
    PBCH_start_i     = pb;
    SSS_start_i      = ss;
    @(posedge clk_i);
    #1;
  endtask

  // drop_at: payload index whose arrival cycle sees tready low (that sample is lost).
  task automatic send_symbol(input int cp, input int n, input bit pb, input bit ss, input bit gaps, input int drop_at);
    logic [DW-1:0] d;
    sym_tag_t      t;
    if (in_progress) exp_aborts++;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0))
        drive(1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, MAXCP), 1'($urandom), 1'($urandom));
      d = $urandom;
      if (i == cp) p0_cyc = cyc;
      m_axis_fft_tready = !(drop_at >= 0 && i == cp + drop_at);
      if (i == 0) drive(1'b1, d, 1'b1, cp, pb, ss);
      else drive(1'b1, d, 1'b0, $urandom_range(0, MAXCP), 1'($urandom), 1'($urandom));
      m_axis_fft_tready = 1'b1;
      if (i >= cp && i < cp + FFT && !(drop_at >= 0 && i == cp + drop_at))
        exp_beats.push_back({(i == cp + FFT - 1), d});
    end
    if (n > cp && drop_at != 0) begin
      t.pbch = pb;
      t.sss  = ss;
      t.num  = SW'(exp_num);
      exp_tags.push_back(t);
    end
    exp_num++;
    in_progress = (n < cp + FFT);
  endtask

  task automatic compare(input string name);
    int errs;
    int nb;
    repeat (4) drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    check_val({name, " beat_count"}, got_beats.size(), exp_beats.size());
    errs = 0;
    nb = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
    for (int i = 0; i < nb; i++) if (got_beats[i] !== exp_beats[i]) errs++;
    check_val({name, " beat_mismatches"}, errs, 0);
    check_val({name, " tag_count"}, got_tags.size(), exp_tags.size());
    for (int i = 0; i < got_tags.size() && i < exp_tags.size(); i++)
      check_val($sformatf("%s tag%0d", name, i), got_tags[i], exp_tags[i]);
    check_val({name, " aborts"}, got_aborts, exp_aborts);
    check_val({name, " tag_without_beat"}, tag_no_beat, 0);
    exp_beats.delete(); got_beats.delete(); exp_tags.delete(); got_tags.delete();
    exp_aborts = 0; got_aborts = 0; tag_no_beat = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, " tvalid"}, m_axis_fft_tvalid, 0);
    check_val({name, " tdata"}, m_axis_fft_tdata, 0);
    check_val({name, " tlast"}, m_axis_fft_tlast, 0);
    check_val({name, " sym_tag"}, sym_tag_o, 0);
    check_val({name, " sym_tag_valid"}, sym_tag_valid_o, 0);
    check_val({name, " abort"}, abort_o, 0);
    check_val({name, " overflow"}, overflow_o, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    reset_i = 1'b0;
    exp_num = 0; in_progress = 0;
    exp_beats.delete(); got_beats.delete(); exp_tags.delete(); got_tags.delete();
    exp_aborts = 0; got_aborts = 0; tag_no_beat = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cp;
    int n;
    reset_i = 1'b1;
    m_axis_fft_tready = 1'b1;
    s_axis_in_tvalid = 1'b0; s_axis_in_tdata = '0; symbol_start_i = 1'b0;
    CP_len_i = '0; PBCH_start_i = 1'b0; SSS_start_i = 1'b0;
    #2;
    check_outputs_zero("reset");
    do_reset();

    send_symbol(20, 20 + FFT, 1'b0, 1'b0, 1'b0, -1);
    check_val("t1 latency", tag_cyc - p0_cyc, 1);
    compare("t1");

    do_reset();
    send_symbol(20, 20 + FFT + 3, 1'b0, 1'b0, 1'b0, -1);
    send_symbol(18, 18 + FFT + 5, 1'b0, 1'b0, 1'b0, -1);
    send_symbol(18, 18 + FFT, 1'b0, 1'b0, 1'b0, -1);
    compare("t2");

    do_reset();
    send_symbol(20, 20 + FFT, 1'b0, 1'b0, 1'b1, -1);
    send_symbol(7, 7 + FFT + 2, 1'b1, 1'b1, 1'b1, -1);
    compare("t3");
    check_val("t3 overflow", overflow_o, 0);

    do_reset();
    send_symbol(20, 20 + 100, 1'b0, 1'b0, 1'b0, -1);
    send_symbol(20, 20 + FFT, 1'b0, 1'b0, 1'b0, -1);
    compare("t5");

    do_reset();
    check_val("t4 overflow_pre", overflow_o, 0);
    send_symbol(20, 20 + FFT, 1'b0, 1'b0, 1'b0, 100);
    compare("t4");
    check_val("t4 overflow", overflow_o, 1);

    send_symbol(20, 20 + FFT, 1'b1, 1'b0, 1'b0, -1);
    send_symbol(20, 20 + FFT, 1'b0, 1'b1, 1'b0, -1);
    send_symbol(20, 20 + 50, 1'b0, 1'b0, 1'b0, -1);
    void'(exp_beats.pop_back());
    check_val("t6 overflow_sticky", overflow_o, 1);
    reset_i = 1'b1;
    #1;
    check_outputs_zero("t6 async_reset");
    compare("t6");
    do_reset();
    send_symbol(2, 2 + FFT, 1'b0, 1'b0, 1'b0, -1);
    compare("t6 after_reset");

    do_reset();
    for (int k = 0; k < 10; k++) begin
      case (k % 4)
        0: cp = 0;
        1: cp = 1;
        default: cp = $urandom_range(2, MAXCP);
      endcase
      if (k != 9 && $urandom_range(0, 2) == 0) n = $urandom_range(1, cp + FFT - 1);
      else n = cp + FFT + $urandom_range(0, 5);
      send_symbol(cp, n, 1'($urandom), 1'($urandom), 1'b1, -1);
    end
    compare("rand");
    check_val("rand overflow", overflow_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
